// File: rtl/move_selector_pkg.sv
// move_selector_pkg: shared move/eval types, eval bounds and selector states
package move_selector_pkg;
  typedef logic [15:0] move_t;
  typedef logic signed [15:0] eval_t;
  localparam eval_t EVAL_NEG_INF = -16'sd32767;
  localparam eval_t EVAL_POS_INF = 16'sd32767;
  typedef enum logic [1:0] {SEL_IDLE, SEL_COLLECT, SEL_DRAIN, SEL_DONE} selector_state_t;
endpackage

// File: rtl/move_selector.sv
// move_selector: reduces a node's (move, eval) stream to the best legal child; BETA_CUTOFF_EN adds beta cutoff
module move_selector
  import move_selector_pkg::*;
#(
  parameter int EVAL_LATENCY = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic signed [15:0] beta_in,
  input  logic               gen_done_in,
  input  move_t              move_in,
  input  eval_t              eval_in,
  input  logic               valid_in,
  output logic               busy_out,
  output logic               abort_out,
  output logic               result_valid_out,
  output move_t              best_move_out,
  output eval_t              best_eval_out,
  output logic [CNT_W-1:0]   nb_legal_out,
  output logic               no_legal_out,
  output logic               cutoff_out
);
  localparam int DW = $clog2(EVAL_LATENCY + 2);
  selector_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  move_t best_move_q, best_move_d;
  eval_t best_eval_q, best_eval_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic no_legal_q, no_legal_d, sample, hit;
`ifdef BETA_CUTOFF_EN
  eval_t beta_q, beta_d;
  logic cut_q, cut_d;
`else
  logic unused_beta;
  assign unused_beta = ^beta_in;
`endif
  always_comb begin
    sample = valid_in && !start_in && (state_q == SEL_COLLECT || state_q == SEL_DRAIN);
`ifdef BETA_CUTOFF_EN
    hit = sample && (eval_in >= beta_q);
    beta_d = start_in ? beta_in : beta_q;
    cut_d = start_in ? 1'b0 : (cut_q || hit);
`else
    hit = 1'b0;
`endif
    state_d = state_q;
    drain_d = drain_q;
    best_move_d = best_move_q;
    best_eval_d = best_eval_q;
    nb_d = nb_q;
    no_legal_d = no_legal_q;
    if (start_in) begin
      state_d = SEL_COLLECT;
      drain_d = DW'(EVAL_LATENCY);
      best_move_d = '0;
      best_eval_d = EVAL_NEG_INF;
      nb_d = '0;
      no_legal_d = 1'b0;
    end else begin
      if (hit || (sample && eval_in > best_eval_q)) begin
        best_move_d = move_in;
        best_eval_d = eval_in;
      end
      if (sample && !(&nb_q)) nb_d = nb_q + 1'b1;
      if (hit) state_d = SEL_DONE;
      else if (state_q == SEL_COLLECT && gen_done_in) state_d = (EVAL_LATENCY == 0) ? SEL_DONE : SEL_DRAIN;
      else if (state_q == SEL_DRAIN) begin
        drain_d = drain_q - 1'b1;
        state_d = (drain_q <= DW'(1)) ? SEL_DONE : SEL_DRAIN;
      end else if (state_q == SEL_DONE) state_d = SEL_IDLE;
      if (state_d == SEL_DONE) no_legal_d = (nb_d == '0);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= SEL_IDLE;
      drain_q <= '0;
      best_move_q <= '0;
      best_eval_q <= EVAL_NEG_INF;
      nb_q <= '0;
      no_legal_q <= 1'b0;
`ifdef BETA_CUTOFF_EN
      beta_q <= EVAL_POS_INF;
      cut_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      best_move_q <= best_move_d;
      best_eval_q <= best_eval_d;
      nb_q <= nb_d;
      no_legal_q <= no_legal_d;
`ifdef BETA_CUTOFF_EN
      beta_q <= beta_d;
      cut_q <= cut_d;
`endif
    end
  end
  assign busy_out = (state_q == SEL_COLLECT) || (state_q == SEL_DRAIN);
  assign result_valid_out = (state_q == SEL_DONE);
  assign best_move_out = best_move_q;
  assign best_eval_out = best_eval_q;
  assign nb_legal_out = nb_q;
  assign no_legal_out = no_legal_q;
`ifdef BETA_CUTOFF_EN
  assign abort_out = hit;
  assign cutoff_out = cut_q;
`else
  assign abort_out = 1'b0;
  assign cutoff_out = 1'b0;
`endif
endmodule
